// File: rtl/br_redirect_ctrl_pkg.sv
// Shared definitions for the branch redirect controller: data width,
// branch condition codes, FSM state encodings and the PC increment.
package br_redirect_ctrl_pkg;

    localparam int unsigned XLEN_DEFAULT = 64;
    localparam int unsigned PC_INC       = 4;

    typedef enum logic [2:0] {
        BR_EQ  = 3'd0,
        BR_NE  = 3'd1,
        BR_LT  = 3'd4,
        BR_GE  = 3'd5,
        BR_LTU = 3'd6,
        BR_GEU = 3'd7
    } br_sel_e;

    typedef enum logic [1:0] {
        BRC_IDLE  = 2'd0,
        BRC_REDIR = 2'd1,
        BRC_DRAIN = 2'd2
    } brc_state_e;

endpackage

// File: rtl/br_redirect_ctrl_cond.sv
// Branch condition evaluator: compares two operands under a branch
// condition code; codes outside the defined set evaluate as not taken.
module br_redirect_ctrl_cond
    import br_redirect_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [2:0]      br_sel,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken
);

    always_comb begin
        taken = 1'b0;
        case (br_sel)
            BR_EQ:   taken = (rs1 == rs2);
            BR_NE:   taken = (rs1 != rs2);
            BR_LT:   taken = ($signed(rs1) <  $signed(rs2));
            BR_GE:   taken = ($signed(rs1) >= $signed(rs2));
            BR_LTU:  taken = (rs1 <  rs2);
            BR_GEU:  taken = (rs1 >= rs2);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/br_redirect_ctrl.sv
// Execute-stage branch resolution and redirect controller.
// Optional statistics counters are enabled with the BR_STATS_EN macro.
module br_redirect_ctrl
    import br_redirect_ctrl_pkg::*;
#(
    parameter int unsigned XLEN         = XLEN_DEFAULT,
    parameter int unsigned FLUSH_CYCLES = 2
`ifdef BR_STATS_EN
    ,
    parameter int unsigned CNT_W        = 32
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic            ex_is_br,
    input  logic            ex_is_jmp,
    input  logic [2:0]      ex_br_sel,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            redir_valid,
    input  logic            redir_ready,
    output logic [XLEN-1:0] redir_pc,
    output logic            flush_if,
    output logic            flush_id
`ifdef BR_STATS_EN
    ,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mispred_cnt
`endif
);

    localparam logic [3:0] CNT_LOAD = (FLUSH_CYCLES == 0) ? 4'd0 : 4'(FLUSH_CYCLES - 1);

    brc_state_e      state_q;
    brc_state_e      state_d;
    logic [3:0]      cnt_q;
    logic [3:0]      cnt_d;
    logic            cond_taken;
    logic            actual_taken;
    logic            resolve;
    logic            mispredict;
    logic            take_redirect;
    logic [XLEN-1:0] correct_pc;

    br_redirect_ctrl_cond #(
        .XLEN (XLEN)
    ) u_cond (
        .br_sel (ex_br_sel),
        .rs1    (ex_rs1),
        .rs2    (ex_rs2),
        .taken  (cond_taken)
    );

    assign ex_ready      = (state_q == BRC_IDLE);
    assign resolve       = ex_valid & ex_ready & (ex_is_br | ex_is_jmp);
    // A jump flag overrides the condition, so br+jmp together resolves as taken.
    assign actual_taken  = ex_is_jmp | cond_taken;
    assign correct_pc    = actual_taken ? ex_target : (ex_pc + XLEN'(PC_INC));
    assign mispredict    = (actual_taken != ex_pred_taken) |
                           (actual_taken & ex_pred_taken & (ex_target != ex_pred_target));
    assign take_redirect = resolve & mispredict;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            BRC_IDLE: begin
                if (take_redirect) begin
                    state_d = BRC_REDIR;
                end
            end
            BRC_REDIR: begin
                if (redir_ready) begin
                    if (FLUSH_CYCLES == 0) begin
                        state_d = BRC_IDLE;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = BRC_DRAIN;
                    end
                end
            end
            BRC_DRAIN: begin
                if (cnt_q == 4'd0) begin
                    state_d = BRC_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = BRC_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BRC_IDLE;
            cnt_q       <= '0;
            redir_pc    <= '0;
            redir_valid <= 1'b0;
            flush_if    <= 1'b0;
            flush_id    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            if (take_redirect) begin
                redir_pc <= correct_pc;
            end
            redir_valid <= (state_d == BRC_REDIR);
            flush_if    <= (state_d != BRC_IDLE);
            flush_id    <= (state_d != BRC_IDLE);
        end
    end

`ifdef BR_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt      <= '0;
            mispred_cnt <= '0;
        end else begin
            if (resolve && (br_cnt != '1)) begin
                br_cnt <= br_cnt + 1'b1;
            end
            if (take_redirect && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_br_redirect_ctrl.sv
// Directed self-checking bench for br_redirect_ctrl (FLUSH_CYCLES = 2).
module tb_br_redirect_ctrl;
    import br_redirect_ctrl_pkg::*;

    localparam int unsigned XL = 64;

    logic          clk;
    logic          rst_n;
    logic          ex_valid;
    logic          ex_ready;
    logic          ex_is_br;
    logic          ex_is_jmp;
    logic [2:0]    ex_br_sel;
    logic [XL-1:0] ex_rs1;
    logic [XL-1:0] ex_rs2;
    logic [XL-1:0] ex_pc;
    logic [XL-1:0] ex_target;
    logic          ex_pred_taken;
    logic [XL-1:0] ex_pred_target;
    logic          redir_valid;
    logic          redir_ready;
    logic [XL-1:0] redir_pc;
    logic          flush_if;
    logic          flush_id;
`ifdef BR_STATS_EN
    logic [31:0]   br_cnt;
    logic [31:0]   mispred_cnt;
`endif

    int checks = 0;
    int errors = 0;

    br_redirect_ctrl #(
        .XLEN         (XL),
        .FLUSH_CYCLES (2)
`ifdef BR_STATS_EN
        ,
        .CNT_W        (32)
`endif
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_is_br       (ex_is_br),
        .ex_is_jmp      (ex_is_jmp),
        .ex_br_sel      (ex_br_sel),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .redir_valid    (redir_valid),
        .redir_ready    (redir_ready),
        .redir_pc       (redir_pc),
        .flush_if       (flush_if),
        .flush_id       (flush_id)
`ifdef BR_STATS_EN
        ,
        .br_cnt         (br_cnt),
        .mispred_cnt    (mispred_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic is_br, input logic is_jmp,
                         input logic [2:0] sel, input logic [XL-1:0] rs1, input logic [XL-1:0] rs2,
                         input logic [XL-1:0] pc, input logic [XL-1:0] target,
                         input logic pred_taken, input logic [XL-1:0] pred_target);
        ex_valid       = valid;
        ex_is_br       = is_br;
        ex_is_jmp      = is_jmp;
        ex_br_sel      = sel;
        ex_rs1         = rs1;
        ex_rs2         = rs2;
        ex_pc          = pc;
        ex_target      = target;
        ex_pred_taken  = pred_taken;
        ex_pred_target = pred_target;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ex_ready === 1'b1 && flush_if === 1'b0 && redir_valid === 1'b0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        redir_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'd0, '0, '0, '0, '0, 1'b0, '0);
        #3;
        checks++;
        if (redir_valid !== 1'b0) begin errors++; $display("FAIL reset_redir_valid: got %b expected 0", redir_valid); end
        checks++;
        if (redir_pc !== 64'h0) begin errors++; $display("FAIL reset_redir_pc: got %0h expected 0", redir_pc); end
        checks++;
        if (flush_if !== 1'b0 || flush_id !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b%b expected 00", flush_if, flush_id); end
        checks++;
        if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ex_ready: got %b expected 1", ex_ready); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_correct_not_taken();
        drive(1'b1, 1'b1, 1'b0, BR_EQ, 64'd5, 64'd6, 64'h40, 64'h80, 1'b0, 64'h0);
        checks++;
        if (ex_ready !== 1'b1) begin errors++; $display("FAIL beq_ex_ready_pre: got %b expected 1", ex_ready); end
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, '0, '0, '0, '0, 1'b0, '0);
        checks++;
        if (redir_valid !== 1'b0) begin errors++; $display("FAIL beq_redir_valid: got %b expected 0", redir_valid); end
        checks++;
        if (ex_ready !== 1'b1) begin errors++; $display("FAIL beq_ex_ready: got %b expected 1", ex_ready); end
        checks++;
        if (flush_if !== 1'b0 || flush_id !== 1'b0) begin errors++; $display("FAIL beq_flush: got %b%b expected 00", flush_if, flush_id); end
    endtask

    task automatic test_mispredict_blt();
        int  flush_run;
        bit  ok;
        redir_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, BR_LT, '1, 64'd1, 64'h100, 64'h80, 1'b0, 64'h0);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, '0, '0, '0, '0, 1'b0, '0);
        checks++;
        if (redir_valid !== 1'b1) begin errors++; $display("FAIL blt_redir_valid: got %b expected 1", redir_valid); end
        checks++;
        if (redir_pc !== 64'h80) begin errors++; $display("FAIL blt_redir_pc: got %0h expected 80", redir_pc); end
        checks++;
        if (ex_ready !== 1'b0) begin errors++; $display("FAIL blt_ex_ready: got %b expected 0", ex_ready); end
        flush_run = 0;
        for (int i = 0; i < 10; i++) begin
            if (flush_if !== 1'b1 || flush_id !== 1'b1) break;
            flush_run++;
            step();
        end
        checks++;
        if (flush_run != 3) begin errors++; $display("FAIL blt_flush_len: got %0d expected 3", flush_run); end
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL blt_return_idle: got timeout expected idle"); end
    endtask

    task automatic test_wrap_pc();
        bit ok;
        redir_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, BR_GEU, 64'd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFC, 64'h40, 1'b1, 64'h40);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, '0, '0, '0, '0, 1'b0, '0);
        checks++;
        if (redir_valid !== 1'b1) begin errors++; $display("FAIL wrap_redir_valid: got %b expected 1", redir_valid); end
        checks++;
        if (redir_pc !== 64'h0) begin errors++; $display("FAIL wrap_redir_pc: got %0h expected 0", redir_pc); end
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wrap_return_idle: got timeout expected idle"); end
    endtask

    task automatic test_jal_target_mismatch();
        bit ok;
        redir_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 3'd0, '0, '0, 64'h300, 64'h240, 1'b1, 64'h200);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, '0, '0, '0, '0, 1'b0, '0);
        checks++;
        if (redir_valid !== 1'b1) begin errors++; $display("FAIL jal_redir_valid: got %b expected 1", redir_valid); end
        checks++;
        if (redir_pc !== 64'h240) begin errors++; $display("FAIL jal_redir_pc: got %0h expected 240", redir_pc); end
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL jal_return_idle: got timeout expected idle"); end
    endtask

    task automatic test_backpressure();
        bit ok;
        redir_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, BR_NE, 64'd3, 64'd3, 64'h1000, 64'h2000, 1'b1, 64'h2000);
        step();
        // Younger mispredicting branch keeps knocking while the redirect is held.
        drive(1'b1, 1'b1, 1'b0, BR_EQ, 64'd1, 64'd1, 64'h5000, 64'h6000, 1'b0, 64'h0);
        for (int i = 0; i < 4; i++) begin
            ex_valid = (i % 2 == 0);
            checks++;
            if (redir_valid !== 1'b1) begin errors++; $display("FAIL bp_redir_valid[%0d]: got %b expected 1", i, redir_valid); end
            checks++;
            if (redir_pc !== 64'h1004) begin errors++; $display("FAIL bp_redir_pc[%0d]: got %0h expected 1004", i, redir_pc); end
            checks++;
            if (ex_ready !== 1'b0) begin errors++; $display("FAIL bp_ex_ready[%0d]: got %b expected 0", i, ex_ready); end
            step();
        end
        ex_valid    = 1'b0;
        redir_ready = 1'b1;
        checks++;
        if (redir_valid !== 1'b1 || redir_pc !== 64'h1004) begin
            errors++; $display("FAIL bp_accept_cycle: got valid=%b pc=%0h expected valid=1 pc=1004", redir_valid, redir_pc);
        end
        step();
        checks++;
        if (redir_valid !== 1'b0 || flush_if !== 1'b1) begin
            errors++; $display("FAIL bp_after_accept: got valid=%b flush=%b expected valid=0 flush=1", redir_valid, flush_if);
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_return_idle: got timeout expected idle"); end
        step();
        checks++;
        if (redir_valid !== 1'b0) begin errors++; $display("FAIL bp_no_extra_redirect: got %b expected 0", redir_valid); end
`ifdef BR_STATS_EN
        checks++;
        if (br_cnt !== 32'd5) begin errors++; $display("FAIL stats_br_cnt: got %0d expected 5", br_cnt); end
        checks++;
        if (mispred_cnt !== 32'd4) begin errors++; $display("FAIL stats_mispred_cnt: got %0d expected 4", mispred_cnt); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [2:0]    sel   [6] = '{BR_EQ, BR_NE, BR_LTU, 3'd0, BR_EQ, 3'd2};
        logic          isbr  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic          isjmp [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [XL-1:0] a     [6] = '{64'd7, 64'd1, 64'd5, 64'd0, 64'd1, 64'd4};
        logic [XL-1:0] b     [6] = '{64'd7, 64'd2, 64'd3, 64'd0, 64'd2, 64'd4};
        logic          pt    [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        redir_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, isbr[i], isjmp[i], sel[i], a[i], b[i], 64'h800, 64'h900, pt[i], 64'h900);
            checks++;
            if (ex_ready !== 1'b1) begin errors++; $display("FAIL b2b_ex_ready[%0d]: got %b expected 1", i, ex_ready); end
            step();
            checks++;
            if (redir_valid !== 1'b0 || flush_if !== 1'b0) begin
                errors++; $display("FAIL b2b_no_redirect[%0d]: got valid=%b flush=%b expected 0 0", i, redir_valid, flush_if);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 3'd0, '0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic test_reset_mid_redir();
        bit ok;
        redir_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, BR_EQ, 64'd9, 64'd9, 64'h400, 64'h480, 1'b0, 64'h0);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, '0, '0, '0, '0, 1'b0, '0);
        checks++;
        if (redir_valid !== 1'b1 || redir_pc !== 64'h480) begin
            errors++; $display("FAIL rst_pre_state: got valid=%b pc=%0h expected valid=1 pc=480", redir_valid, redir_pc);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (redir_valid !== 1'b0 || redir_pc !== 64'h0) begin
            errors++; $display("FAIL rst_mid_redir: got valid=%b pc=%0h expected valid=0 pc=0", redir_valid, redir_pc);
        end
        checks++;
        if (flush_if !== 1'b0 || flush_id !== 1'b0 || ex_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_ctrl: got flush=%b%b ready=%b expected 00 1", flush_if, flush_id, ex_ready);
        end
`ifdef BR_STATS_EN
        checks++;
        if (br_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
            errors++; $display("FAIL rst_stats: got %0d/%0d expected 0/0", br_cnt, mispred_cnt);
        end
`endif
        rst_n       = 1'b1;
        redir_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, BR_LTU, 64'd1, 64'd2, 64'h600, 64'h700, 1'b0, 64'h0);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, '0, '0, '0, '0, 1'b0, '0);
        checks++;
        if (redir_valid !== 1'b1 || redir_pc !== 64'h700) begin
            errors++; $display("FAIL post_rst_resolve: got valid=%b pc=%0h expected valid=1 pc=700", redir_valid, redir_pc);
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL post_rst_return_idle: got timeout expected idle"); end
`ifdef BR_STATS_EN
        checks++;
        if (br_cnt !== 32'd1 || mispred_cnt !== 32'd1) begin
            errors++; $display("FAIL post_rst_stats: got %0d/%0d expected 1/1", br_cnt, mispred_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_correct_not_taken();
        test_mispredict_blt();
        test_wrap_pc();
        test_jal_target_mismatch();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_redir();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/br_redirect_ctrl.md
Name: br_redirect_ctrl

Overview:
- Execute-stage branch resolution and redirect controller.
- Evaluates branch/jump outcome through an internal branch-condition instance and compares it against the fetch-stage prediction.
- On mispredict: sequences the redirect handshake to fetch, flushes the IF/ID stages, and holds EX until the pipeline has drained.
- Sits between the EX stage, the fetch PC unit and the hazard unit.

Parameters:
- XLEN, 64, data/PC width (global `XLEN).
- FLUSH_CYCLES, 2, extra flush cycles after redirect acceptance (0..15).
- CNT_W, 32, statistics counter width (BR_STATS_EN only).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX holds a valid instruction.
- ex_ready  out  1  EX may resolve/advance this cycle.
- ex_is_br  in  1  conditional branch.
- ex_is_jmp  in  1  unconditional jump (JAL/JALR).
- ex_br_sel  in  3  branch condition code (`BR_EQ..`BR_GEU).
- ex_rs1  in  XLEN  operand A.
- ex_rs2  in  XLEN  operand B.
- ex_pc  in  XLEN  instruction PC.
- ex_target  in  XLEN  computed taken target.
- ex_pred_taken  in  1  fetch prediction: taken.
- ex_pred_target  in  XLEN  fetch predicted target.
- redir_valid  out  1  redirect request to fetch.
- redir_ready  in  1  fetch accepts redirect.
- redir_pc  out  XLEN  corrected PC.
- flush_if  out  1  kill IF stage contents.
- flush_id  out  1  kill ID stage contents.

Behaviour:
- Resolve event: ex_valid & ex_ready & (ex_is_br | ex_is_jmp). If both flags are set, treat as a jump.
- actual_taken = ex_is_jmp | cond_taken, where cond_taken comes from the internal condition evaluator on ex_br_sel/ex_rs1/ex_rs2. An unknown br_sel gives cond_taken = 0.
- correct_pc = actual_taken ? ex_target : ex_pc + 4, computed modulo 2^XLEN (wraps, no overflow flag).
- mispredict = (actual_taken != ex_pred_taken) | (actual_taken & ex_pred_taken & ex_target != ex_pred_target).
- FSM states: IDLE, REDIR, DRAIN.
- IDLE:
  - ex_ready = 1, redir_valid = 0, flushes = 0.
  - Resolve with mispredict: latch correct_pc into redir_pc and go to REDIR on the next edge.
  - Resolve without mispredict: stay in IDLE. Back-to-back correct branches resolve every cycle.
- REDIR:
  - redir_valid = 1, flush_if = flush_id = 1, ex_ready = 0.
  - redir_pc is held stable until the handshake completes.
  - On redir_valid & redir_ready: if FLUSH_CYCLES == 0 go to IDLE; else load cnt = FLUSH_CYCLES-1 and go to DRAIN.
  - Holding redir_valid while ready is low is mandatory; the request is never dropped.
- DRAIN:
  - flush_if = flush_id = 1, ex_ready = 0, redir_valid = 0.
  - cnt == 0 → IDLE, else cnt decrements.
- Latency: redir_valid rises exactly 1 cycle after the mispredicting resolve cycle.
- Outside IDLE, ex_valid is ignored; the EX instruction is stalled via ex_ready = 0.
- Reset (async assert, any state): state = IDLE, redir_valid = 0, redir_pc = 0, flush_if = flush_id = 0, ex_ready = 1, cnt = 0, statistics counters = 0.
- Reset mid-REDIR discards the pending redirect.
- All outputs are driven from registered state except ex_ready, which is decoded from state.

Optional Feature:
- Macro: BR_STATS_EN.
- Defined:
  - Adds output br_cnt [CNT_W] (count of resolve events) and output mispred_cnt [CNT_W] (count of mispredicting resolves).
  - Both counters saturate at all-ones and are cleared by reset.
- Undefined: neither the ports nor the counter logic exist; all other behaviour is identical.

Decomposition:
- Shared package/define file holds:
  - existing `BR_* condition codes and `XLEN;
  - FSM state encodings BRC_IDLE = 2'd0, BRC_REDIR = 2'd1, BRC_DRAIN = 2'd2;
  - the PC increment constant 4.
- One sub-module: the existing BrCond condition evaluator, instantiated once for cond_taken.
- Counter, FSM and redirect register stay in br_redirect_ctrl.

Test Plan:
1. Correct not-taken BEQ: rs1 = 5, rs2 = 6, pred_taken = 0 → no redir_valid, ex_ready stays 1, no flush.
2. Mispredicted BLT: rs1 = -1, rs2 = 1, pred_taken = 0, pc = 0x100, target = 0x80, redir_ready = 1 → next cycle redir_valid = 1 and redir_pc = 0x80. Flush is then high for 1 + FLUSH_CYCLES = 3 cycles, then IDLE.
3. Taken prediction, not actually taken: BGEU with rs1 = 1, rs2 = 2, pc = 0xFFFFFFFFFFFFFFFC → redir_pc = 0x0 (wrap).
4. Target mismatch on a JAL: pred_taken = 1, pred_target = 0x200, target = 0x240 → redirect to 0x240.
5. Backpressure: redir_ready low for 4 cycles during REDIR, with ex_valid toggling → redir_pc stable, ex_ready = 0, no extra resolves; accept on cycle 5.
6. rst_n pulsed low mid-REDIR → all outputs return to reset values immediately; a branch on the first post-reset cycle resolves normally. With BR_STATS_EN defined, tests 1–5 end with br_cnt = 5 and mispred_cnt = 4.
